nibble_serial_adder: RTL

//  Multi-cycle WIDTH-bit adder that feeds one 4-bit ripple slice ({c,s} = x + y + c) a nibble per cycle, LSB first.
//  A registered carry links the nibbles, and the partial sum is assembled in a result register.

---
 rtl/nibble_serial_adder.sv | 119 +++++++++++
 1 files changed

// File: rtl/nibble_serial_adder.sv
// Multi-cycle adder: one 4-bit ripple slice processes a nibble per cycle, LSB first,
// with a registered carry between nibbles and ready/valid handshakes on both sides.
module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf
);

  localparam int N_NIB = WIDTH / 4;
  localparam int IDXW  = (N_NIB > 1) ? $clog2(N_NIB) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N_NIB - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [3:0]       nib_a;
  logic [3:0]       nib_b;
  logic [4:0]       slice;
  logic [IDXW+1:0]  bit_pos;

  // The ripple slice: selects the current nibble of each captured operand
  assign bit_pos = {idx_q, 2'b00};
  assign nib_a   = 4'(a_q >> bit_pos);
  assign nib_b   = 4'(b_q >> bit_pos);
  assign slice   = {1'b0, nib_a} + {1'b0, nib_b} + {4'b0000, carry_q};

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = A;
          b_d     = B;
          carry_d = Cin;
          idx_d   = '0;
          sum_d   = '0;
          state_d = ADD;
        end
      end
      ADD: begin
        // Sum is cleared on accept, so OR-ing the shifted slice fills the nibble
        sum_d   = sum_q | (WIDTH'(slice[3:0]) << bit_pos);
        carry_d = slice[4];
        idx_d   = idx_q + IDXW'(1);
        if (idx_q == LAST_IDX) begin
          cout_d  = slice[4];
          ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_d[WIDTH-1] != a_q[WIDTH-1]);
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == DONE);
  assign Sum       = sum_q;
  assign Cout      = cout_q;
  assign Ovf       = ovf_q;

endmodule
